rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Registered, handshaked RISC-V decode stage between instruction fetch and execute.
- Successor to the combinational mnemonic decoder. Parametrised for RV32/RV64 (XLEN).
- Emits structured fields: an op enum, register indices, and an XLEN-wide sign-extended immediate.
- Adds illegal-instruction detection, a halt-on-illegal FSM, and a pipeline flush.

Parameters:
- XLEN, 64, datapath width. Only 32 and 64 are legal; any other value is an elaboration error.
- HALT_ON_ILLEGAL, 1, when 1 the stage stops accepting after emitting an illegal instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard the held instruction and leave HALT.
- in_valid  in  1  fetch holds an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ir  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_ir.
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  execute accepts this cycle.
- out_pc  out  XLEN  registered PC.
- out_op  out  decode_pkg::op_e  decoded operation.
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when the format does not use the field.
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J format); 0 for R-type.
- out_illegal  out  1  instruction is not legal for this configuration.
- illegal_cnt  out  16  saturating count of illegal instructions emitted.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_illegal=0, out_op=OP_NOP, every other output field=0, illegal_cnt=0, FSM=RUN.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - Latency is 1 cycle: the decoded result is registered on the next edge.
- Output stability: out_* stay stable while out_valid && !out_ready.
- Throughput: one instruction per cycle under continuous ready.
- FSM states: RUN, HALT.
  - RUN -> HALT when an accepted instruction decodes as illegal and HALT_ON_ILLEGAL=1.
  - HALT: in_ready=0; the illegal instruction is still presented until consumed.
  - HALT -> RUN only on flush.
- Flush:
  - Takes priority over a simultaneous accept.
  - Next cycle: out_valid=0, out_illegal=0, state=RUN, and nothing is captured that cycle.
  - illegal_cnt is not cleared.
- illegal_cnt: increments on an output handshake with out_illegal=1; saturates at 0xFFFF.
- Decode coverage: RV32I/RV64I opcodes LOAD, STORE, OP-IMM, OP, BRANCH, LUI, AUIPC, JAL, JALR, MISC-MEM, SYSTEM, OP-IMM-32, OP-32.
- Illegal conditions:
  - Unknown opcode; ir[1:0]!=2'b11.
  - Undefined funct3/funct7 combination.
  - BRANCH funct3 010 or 011.
  - ecall must be exactly 0x00000073 and ebreak exactly 0x00100073; any other funct3=000 SYSTEM word is illegal.
  - When XLEN==32: LD, SD, LWU, OP-IMM-32, OP-32, and shamt[5]=1 are illegal.
- Illegal output: out_op=OP_ILLEGAL; the other fields are don't-care but deterministic (0).
- Immediate: sign-extended from bit ir[31] to XLEN; the U-type immediate is {ir[31:12],12'b0}, sign-extended.

Optional Feature:
- Macro: RV_DECODE_MEXT_EN.
- Defined: funct7=0000001 on OP decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. On OP-32 with XLEN=64 it decodes MULW, DIVW, DIVUW, REMW, REMUW.
- Undefined: those encodings are illegal.

Decomposition:
- decode_pkg:
  - op_e enum (OP_NOP, OP_ILLEGAL, every mnemonic).
  - 7-bit opcode localparams.
  - imm_fmt_e (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
  - funct7 constants.
- Sub-module rv_imm_gen: combinational; (ir, imm_fmt) -> XLEN immediate.
- The FSM, registers and main decode case stay in rv_decode_stage.

Test Plan:
- XLEN=64, in_ir=0xFFF10093 (addi x1,x2,-1) -> next cycle out_op=OP_ADDI, rd=1, rs1=2, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_illegal=0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while in_valid=1 with two different words.
  - Response: the first result is held unchanged and in_ready=0. After out_ready=1, the second result appears on the following cycle and nothing is dropped or duplicated.
- Halt on illegal, in_ir=0x00000000:
  - out_illegal=1, out_op=OP_ILLEGAL, in_ready=0 after consumption, illegal_cnt=1.
  - flush -> in_ready=1 and state=RUN next cycle.
- in_ir=0x0020803B (addw x0,x1,x2):
  - XLEN=64 -> OP_ADDW.
  - XLEN=32 -> out_illegal=1.
- in_ir=0x022081B3 (mul x3,x1,x2):
  - With RV_DECODE_MEXT_EN -> OP_MUL, rd=3.
  - Without it -> out_illegal=1.
- Flush asserted together with in_valid=1 and a valid word:
  - out_valid=0 next cycle and no instruction captured.
  - Asserting rst_n=0 mid-stream clears out_valid immediately (asynchronous).

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and encodings for the RISC-V decode stage.
// M-extension op codes exist unconditionally; RV_DECODE_MEXT_EN only gates their decode.
package decode_pkg;

    typedef enum logic [6:0] {
        OP_NOP, OP_ILLEGAL,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } op_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
    } imm_fmt_e;

    localparam logic [6:0] OpcLoad     = 7'b0000011;
    localparam logic [6:0] OpcMiscMem  = 7'b0001111;
    localparam logic [6:0] OpcOpImm    = 7'b0010011;
    localparam logic [6:0] OpcAuipc    = 7'b0010111;
    localparam logic [6:0] OpcOpImm32  = 7'b0011011;
    localparam logic [6:0] OpcStore    = 7'b0100011;
    localparam logic [6:0] OpcOp       = 7'b0110011;
    localparam logic [6:0] OpcLui      = 7'b0110111;
    localparam logic [6:0] OpcOp32     = 7'b0111011;
    localparam logic [6:0] OpcBranch   = 7'b1100011;
    localparam logic [6:0] OpcJalr     = 7'b1100111;
    localparam logic [6:0] OpcJal      = 7'b1101111;
    localparam logic [6:0] OpcSystem   = 7'b1110011;

    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
    localparam logic [6:0] F7MulDiv = 7'b0000001;

    localparam logic [31:0] IrEcall  = 32'h0000_0073;
    localparam logic [31:0] IrEbreak = 32'h0010_0073;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: selects the format and sign-extends from ir[31] to XLEN.
module rv_imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:7]     ir,
    input  imm_fmt_e        imm_fmt,
    output logic [XLEN-1:0] imm
);

    logic [63:0] imm64;

    // Built at 64 bits and truncated so XLEN=32 needs no zero-width replication.
    always_comb begin
        imm64 = 64'd0;
        unique case (imm_fmt)
            IMM_I: imm64 = {{52{ir[31]}}, ir[31:20]};
            IMM_S: imm64 = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B: imm64 = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U: imm64 = {{32{ir[31]}}, ir[31:12], 12'b0};
            IMM_J: imm64 = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm64 = 64'd0;
        endcase
    end

    assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/rv_decode_stage.sv
// Registered, handshaked RV32I/RV64I decode stage with illegal detection, halt and flush.
// Define RV_DECODE_MEXT_EN to decode the M extension; otherwise those encodings are illegal.
module rv_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN            = 64,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output op_e             out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic [15:0]     illegal_cnt
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("rv_decode_stage: XLEN must be 32 or 64");
    end

    localparam bit Rv64 = (XLEN == 64);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e          state_q;
    op_e             dec_op;
    imm_fmt_e        dec_fmt;
    imm_fmt_e        imm_fmt;
    logic            use_rd, use_rs1, use_rs2;
    logic            dec_illegal;
    logic            accept;
    logic [XLEN-1:0] dec_imm;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       shamt_ok;

    assign opcode   = in_ir[6:0];
    assign funct3   = in_ir[14:12];
    assign funct7   = in_ir[31:25];
    // shamt[5] only exists on RV64.
    assign shamt_ok = Rv64 || !in_ir[25];

    // Every legal opcode ends in 2'b11, so compressed encodings fall into the default arm.
    always_comb begin
        dec_op  = OP_ILLEGAL;
        dec_fmt = IMM_NONE;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OpcLui:   begin dec_op = OP_LUI;   dec_fmt = IMM_U; use_rd = 1'b1; end
            OpcAuipc: begin dec_op = OP_AUIPC; dec_fmt = IMM_U; use_rd = 1'b1; end
            OpcJal:   begin dec_op = OP_JAL;   dec_fmt = IMM_J; use_rd = 1'b1; end
            OpcJalr: begin
                dec_fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                if (funct3 == 3'b000) dec_op = OP_JALR;
            end
            OpcBranch: begin
                dec_fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            OpcLoad: begin
                dec_fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OP_LB;
                    3'b001:  dec_op = OP_LH;
                    3'b010:  dec_op = OP_LW;
                    3'b011:  dec_op = Rv64 ? OP_LD : OP_ILLEGAL;
                    3'b100:  dec_op = OP_LBU;
                    3'b101:  dec_op = OP_LHU;
                    3'b110:  dec_op = Rv64 ? OP_LWU : OP_ILLEGAL;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            OpcStore: begin
                dec_fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OP_SB;
                    3'b001:  dec_op = OP_SH;
                    3'b010:  dec_op = OP_SW;
                    3'b011:  dec_op = Rv64 ? OP_SD : OP_ILLEGAL;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            OpcOpImm: begin
                dec_fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                case (funct3)
                    3'b000: dec_op = OP_ADDI;
                    3'b010: dec_op = OP_SLTI;
                    3'b011: dec_op = OP_SLTIU;
                    3'b100: dec_op = OP_XORI;
                    3'b110: dec_op = OP_ORI;
                    3'b111: dec_op = OP_ANDI;
                    3'b001: if (in_ir[31:26] == 6'b000000 && shamt_ok) dec_op = OP_SLLI;
                    default: begin
                        if (in_ir[31:26] == 6'b000000 && shamt_ok)      dec_op = OP_SRLI;
                        else if (in_ir[31:26] == 6'b010000 && shamt_ok) dec_op = OP_SRAI;
                    end
                endcase
            end
            OpcOp: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct7)
                    F7Base: begin
                        unique case (funct3)
                            3'b000: dec_op = OP_ADD;
                            3'b001: dec_op = OP_SLL;
                            3'b010: dec_op = OP_SLT;
                            3'b011: dec_op = OP_SLTU;
                            3'b100: dec_op = OP_XOR;
                            3'b101: dec_op = OP_SRL;
                            3'b110: dec_op = OP_OR;
                            3'b111: dec_op = OP_AND;
                        endcase
                    end
                    F7Alt: begin
                        if (funct3 == 3'b000)      dec_op = OP_SUB;
                        else if (funct3 == 3'b101) dec_op = OP_SRA;
                    end
`ifdef RV_DECODE_MEXT_EN
                    F7MulDiv: begin
                        unique case (funct3)
                            3'b000: dec_op = OP_MUL;
                            3'b001: dec_op = OP_MULH;
                            3'b010: dec_op = OP_MULHSU;
                            3'b011: dec_op = OP_MULHU;
                            3'b100: dec_op = OP_DIV;
                            3'b101: dec_op = OP_DIVU;
                            3'b110: dec_op = OP_REM;
                            3'b111: dec_op = OP_REMU;
                        endcase
                    end
`else
                    F7MulDiv: dec_op = OP_ILLEGAL;
`endif
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            OpcMiscMem: begin
                dec_fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                if (funct3 == 3'b000) dec_op = OP_FENCE;
            end
            OpcSystem: begin
                if (in_ir == IrEcall)       dec_op = OP_ECALL;
                else if (in_ir == IrEbreak) dec_op = OP_EBREAK;
            end
            OpcOpImm32: begin
                dec_fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                if (Rv64) begin
                    if (funct3 == 3'b000)                          dec_op = OP_ADDIW;
                    else if (funct3 == 3'b001 && funct7 == F7Base) dec_op = OP_SLLIW;
                    else if (funct3 == 3'b101 && funct7 == F7Base) dec_op = OP_SRLIW;
                    else if (funct3 == 3'b101 && funct7 == F7Alt)  dec_op = OP_SRAIW;
                end
            end
            OpcOp32: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (Rv64) begin
                    if (funct7 == F7Base) begin
                        if (funct3 == 3'b000)      dec_op = OP_ADDW;
                        else if (funct3 == 3'b001) dec_op = OP_SLLW;
                        else if (funct3 == 3'b101) dec_op = OP_SRLW;
                    end else if (funct7 == F7Alt) begin
                        if (funct3 == 3'b000)      dec_op = OP_SUBW;
                        else if (funct3 == 3'b101) dec_op = OP_SRAW;
                    end
`ifdef RV_DECODE_MEXT_EN
                    else if (funct7 == F7MulDiv) begin
                        case (funct3)
                            3'b000:  dec_op = OP_MULW;
                            3'b100:  dec_op = OP_DIVW;
                            3'b101:  dec_op = OP_DIVUW;
                            3'b110:  dec_op = OP_REMW;
                            3'b111:  dec_op = OP_REMUW;
                            default: dec_op = OP_ILLEGAL;
                        endcase
                    end
`endif
                end
            end
            default: dec_op = OP_ILLEGAL;
        endcase
    end

    assign dec_illegal = (dec_op == OP_ILLEGAL);
    assign imm_fmt     = dec_illegal ? IMM_NONE : dec_fmt;

    rv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .ir      (in_ir[31:7]),
        .imm_fmt (imm_fmt),
        .imm     (dec_imm)
    );

    assign in_ready = (state_q == StRun) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op      <= OP_NOP;
            out_rd      <= 5'd0;
            out_rs1     <= 5'd0;
            out_rs2     <= 5'd0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
            illegal_cnt <= 16'd0;
        end else begin
            // Counting is tied to the output handshake, so a flush does not hide it.
            if (out_valid && out_ready && out_illegal && illegal_cnt != 16'hFFFF) begin
                illegal_cnt <= illegal_cnt + 16'd1;
            end
            if (flush) begin
                state_q     <= StRun;
                out_valid   <= 1'b0;
                out_illegal <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_op      <= dec_op;
                out_rd      <= (use_rd  && !dec_illegal) ? in_ir[11:7]  : 5'd0;
                out_rs1     <= (use_rs1 && !dec_illegal) ? in_ir[19:15] : 5'd0;
                out_rs2     <= (use_rs2 && !dec_illegal) ? in_ir[24:20] : 5'd0;
                out_imm     <= dec_imm;
                out_illegal <= dec_illegal;
                if (dec_illegal && HALT_ON_ILLEGAL) state_q <= StHalt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage: an RV64 and an RV32 instance share stimulus.
module tb_rv_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_ir;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_pc, out_imm;
    op_e         out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [15:0] illegal_cnt;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_pc32, out_imm32;
    op_e         out_op32;
    logic [4:0]  out_rd32, out_rs132, out_rs232;
    logic [15:0] illegal_cnt32;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(64), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    rv_decode_stage #(.XLEN(32), .HALT_ON_ILLEGAL(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_ir(in_ir), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
        .out_pc(out_pc32), .out_op(out_op32), .out_rd(out_rd32), .out_rs1(out_rs132),
        .out_rs2(out_rs232), .out_imm(out_imm32), .out_illegal(out_illegal32),
        .illegal_cnt(illegal_cnt32)
    );

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ir, input logic [63:0] pc);
        in_valid = 1'b1;
        in_ir    = ir;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume_and_flush();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    localparam int NVec = 10;
    logic [31:0] v_ir   [NVec] = '{32'h800002B7, 32'hFE20BC23, 32'hFE208EE3, 32'h001000EF,
                                   32'h03F09093, 32'h00000073, 32'h00000173, 32'h00002063,
                                   32'h4020D1BB, 32'h00013083};
    op_e         v_op64 [NVec] = '{OP_LUI, OP_SD, OP_BEQ, OP_JAL, OP_SLLI, OP_ECALL, OP_ILLEGAL,
                                   OP_ILLEGAL, OP_SRAW, OP_LD};
    op_e         v_op32 [NVec] = '{OP_LUI, OP_ILLEGAL, OP_BEQ, OP_JAL, OP_ILLEGAL, OP_ECALL,
                                   OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL};
    logic [63:0] v_imm  [NVec] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFF8,
                                   64'hFFFF_FFFF_FFFF_FFFC, 64'h800, 64'h3F, 64'h0, 64'h0,
                                   64'h0, 64'h0, 64'h0};
    logic [4:0]  v_rd   [NVec] = '{5'd5, 5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd3, 5'd1};

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ir = 32'd0; in_pc = 64'd0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_op", 64'(out_op), 64'(OP_NOP));
        check("rst_illegal", 64'(out_illegal), 64'd0);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        check("rst_imm", out_imm, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // addi x1,x2,-1
        send(32'hFFF10093, 64'h1000);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_op", 64'(out_op), 64'(OP_ADDI));
        check("addi_rd", 64'(out_rd), 64'd1);
        check("addi_rs1", 64'(out_rs1), 64'd2);
        check("addi_rs2", 64'(out_rs2), 64'd0);
        check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_illegal", 64'(out_illegal), 64'd0);
        check("addi_pc", out_pc, 64'h1000);
        check("addi_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
        tick();
        check("addi_consumed", 64'(out_valid), 64'd0);

        // Backpressure: add x5,x6,x7 held while sub x8,x9,x10 waits
        out_ready = 1'b0;
        send(32'h007302B3, 64'h2000);
        in_valid = 1'b1; in_ir = 32'h40A48433; in_pc = 64'h2004;
        check("bp_op0", 64'(out_op), 64'(OP_ADD));
        check("bp_ready0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_hold_op", 64'(out_op), 64'(OP_ADD));
            check("bp_hold_rd", 64'(out_rd), 64'd5);
            check("bp_hold_rs2", 64'(out_rs2), 64'd7);
            check("bp_hold_pc", out_pc, 64'h2000);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_second_op", 64'(out_op), 64'(OP_SUB));
        check("bp_second_rd", 64'(out_rd), 64'd8);
        check("bp_second_rs1", 64'(out_rs1), 64'd9);
        check("bp_second_rs2", 64'(out_rs2), 64'd10);
        check("bp_second_pc", out_pc, 64'h2004);
        tick();
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_handshakes", 64'(hs_cnt), 64'd3);

        // Halt on illegal all-zero word
        send(32'h0000_0000, 64'h3000);
        exp_cnt++;
        check("halt_illegal", 64'(out_illegal), 64'd1);
        check("halt_op", 64'(out_op), 64'(OP_ILLEGAL));
        check("halt_rd", 64'(out_rd), 64'd0);
        check("halt_imm", out_imm, 64'd0);
        check("halt_ready_held", 64'(in_ready), 64'd0);
        tick();
        check("halt_consumed", 64'(out_valid), 64'd0);
        check("halt_ready", 64'(in_ready), 64'd0);
        check("halt_cnt", 64'(illegal_cnt), 64'd1);
        send(32'hFFF10093, 64'h3004);
        check("halt_no_accept", 64'(out_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_ready32", 64'(in_ready32), 64'd1);
        check("flush_cnt_kept", 64'(illegal_cnt), 64'd1);

        // addw x0,x1,x2
        send(32'h0020803B, 64'h4000);
        check("addw_op64", 64'(out_op), 64'(OP_ADDW));
        check("addw_rs2", 64'(out_rs2), 64'd2);
        check("addw_illegal64", 64'(out_illegal), 64'd0);
        check("addw_illegal32", 64'(out_illegal32), 64'd1);
        check("addw_op32", 64'(out_op32), 64'(OP_ILLEGAL));
        consume_and_flush();

        // mul x3,x1,x2
        send(32'h022081B3, 64'h5000);
`ifdef RV_DECODE_MEXT_EN
        check("mul_op", 64'(out_op), 64'(OP_MUL));
        check("mul_rd", 64'(out_rd), 64'd3);
        check("mul_illegal", 64'(out_illegal), 64'd0);
`else
        exp_cnt++;
        check("mul_op", 64'(out_op), 64'(OP_ILLEGAL));
        check("mul_illegal", 64'(out_illegal), 64'd1);
`endif
        consume_and_flush();

        for (int i = 0; i < NVec; i++) begin
            send(v_ir[i], 64'h6000 + 64'(4 * i));
            if (v_op64[i] == OP_ILLEGAL) exp_cnt++;
            check($sformatf("vec%0d_op64", i), 64'(out_op), 64'(v_op64[i]));
            check($sformatf("vec%0d_imm64", i), out_imm, v_imm[i]);
            check($sformatf("vec%0d_rd", i), 64'(out_rd), 64'(v_rd[i]));
            check($sformatf("vec%0d_op32", i), 64'(out_op32), 64'(v_op32[i]));
            consume_and_flush();
        end
        check("cnt_total", 64'(illegal_cnt), 64'(exp_cnt));

        // Flush beats a simultaneous accept
        in_valid = 1'b1; in_ir = 32'hFFF10093; in_pc = 64'h7000; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_valid", 64'(out_valid), 64'd0);
        tick();
        check("flush_accept_still", 64'(out_valid), 64'd0);
        check("flush_accept_hs", 64'(hs_cnt), 64'(3 + 3 + NVec));

        // Asynchronous reset mid-cycle
        out_ready = 1'b0;
        send(32'hFFF10093, 64'h8000);
        check("arst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_op", 64'(out_op), 64'(OP_NOP));
        check("arst_cnt", 64'(illegal_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
